// File: rtl/ysyx_220053_dmem_responder_pkg.sv
// Shared types and elaboration-time helpers for the data-memory responder.
package ysyx_220053_dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    // Number of byte-offset bits inside one data word.
    function automatic int unsigned off_bits(input int unsigned data_width);
        return clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/ysyx_220053_dmem_responder_if.sv
// LSU request/response channel between the core (master) and the responder (slave).
interface ysyx_220053_dmem_responder_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_wen;
    logic [31:0]             req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wmask;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_220053_dmem_array.sv
// Word-organised storage with one byte-masked synchronous write port and one
// asynchronous read port. Contents are never reset.
module ysyx_220053_dmem_array #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Commit only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (wmask[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ysyx_220053_dmem_responder.sv
// Data-memory responder: accepts one LSU request, performs the access at the
// accept edge, and presents the result after LATENCY cycles until taken.
module ysyx_220053_dmem_responder
    import ysyx_220053_dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int LATENCY    = 2
) (
    input logic clk,
    input logic rst,
    ysyx_220053_dmem_responder_if.slave bus
);
    localparam int unsigned OFF = off_bits(DATA_WIDTH);
    localparam int unsigned CW  = clog2(LATENCY + 1);
    localparam int unsigned HI  = OFF + ADDR_WIDTH;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [DATA_WIDTH-1:0]   arr_rdata;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    req_err;
    logic                    accept;
    logic                    wr_en;

    assign word_idx = bus.req_addr[HI-1:OFF];

    if (OFF == 0) begin : g_no_off
        assign misaligned = 1'b0;
    end else begin : g_off
        assign misaligned = |bus.req_addr[OFF-1:0];
    end

    if (HI < 32) begin : g_hi_bits
        assign out_of_range = |bus.req_addr[31:HI];
    end else begin : g_no_hi_bits
        assign out_of_range = 1'b0;
    end

    assign req_err = misaligned | out_of_range;
    assign accept  = bus.req_valid & bus.req_ready;
    assign wr_en   = accept & bus.req_wen & ~req_err;

    ysyx_220053_dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (wr_en),
        .waddr(word_idx),
        .wdata(bus.req_wdata),
        .wmask(bus.req_wmask),
        .raddr(word_idx),
        .rdata(arr_rdata)
    );

    // Transaction FSM with registered handshake outputs and response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.resp_err   <= req_err;
                        bus.resp_rdata <= (!bus.req_wen && !req_err) ? arr_rdata : '0;
                        bus.req_ready  <= 1'b0;
                        if (LATENCY == 1) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
